// File: rtl/memwb_pkg.sv
// Shared definitions for the MEM->WB stage: load funct3 encodings and state enum.
package memwb_pkg;

    // Load-type encodings as they arrive on funct3
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LD  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] LWU = 3'd6;

    // Occupancy of the two-entry elastic buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } memwb_state_e;

endpackage

// File: rtl/memwb_stage_load_align.sv
// Load formatter: picks the addressed byte/half/word out of a naturally
// aligned memory word, sign- or zero-extends it, and flags misaligned loads.
// Purely combinational; misaligned loads produce zero data.
module load_align
    import memwb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  raw_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [2:0]       funct3_i,
    output logic [XLEN-1:0]  data_o,
    output logic             misaligned_o
);

    logic [OFF_W+2:0] sh;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    // Slice the addressed element, then extend according to the load type
    always_comb begin
        sh           = {off_i, 3'b000};
        byte_v       = 8'(raw_i >> sh);
        half_v       = 16'(raw_i >> sh);
        word_v       = 32'(raw_i >> sh);
        data_o       = raw_i;
        misaligned_o = 1'b0;
        case (funct3_i)
            LB:  data_o = XLEN'($signed(byte_v));
            LBU: data_o = XLEN'(byte_v);
            LH: begin
                misaligned_o = off_i[0];
                data_o       = XLEN'($signed(half_v));
            end
            LHU: begin
                misaligned_o = off_i[0];
                data_o       = XLEN'(half_v);
            end
            LW: begin
                misaligned_o = |off_i[1:0];
                data_o       = (XLEN == 64) ? XLEN'($signed(word_v)) : raw_i;
            end
            LWU: begin
                // On RV32 LWU does not exist; treat it as a plain word load
                misaligned_o = |off_i[1:0];
                data_o       = (XLEN == 64) ? XLEN'(word_v) : raw_i;
            end
            LD: begin
                // On RV32 a doubleword code degrades to a word load
                misaligned_o = |off_i;
                data_o       = raw_i;
            end
            default: ;
        endcase
        if (misaligned_o)
            data_o = '0;
    end

endmodule

// File: rtl/memwb_stage.sv
// MEM->WB pipeline stage: two-entry elastic buffer (head + skid) with
// valid/ready handshakes on both sides. Load data is formatted before it is
// stored, so buffered entries are already in final write-back form.
// mem_ready and all wb_* outputs come from registers only.
module memwb_stage
    import memwb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    localparam int OFF_W     = $clog2(XLEN/8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [XLEN-1:0]       mem_rd_data,
    input  logic [XLEN-1:0]       mem_load_data,
    input  logic [OFF_W-1:0]      mem_addr_lo,
    input  logic [2:0]            mem_funct3,
    input  logic [REG_ADDR_W-1:0] mem_write_addr,
    input  logic                  mem_regwrite,
    input  logic                  mem_memtoreg,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [XLEN-1:0]       wb_wdata,
    output logic [REG_ADDR_W-1:0] wb_write_addr,
    output logic                  wb_regwrite,
    output logic                  wb_misaligned
);

    typedef struct packed {
        logic [XLEN-1:0]       wdata;
        logic [REG_ADDR_W-1:0] write_addr;
        logic                  regwrite;
        logic                  misaligned;
    } entry_t;

    memwb_state_e state_q, state_d;
    entry_t       h_q, h_d;
    entry_t       s_q, s_d;
    entry_t       in_entry;

    logic [XLEN-1:0] fmt_data;
    logic            fmt_mis;
    logic            accept;
    logic            consume;

    load_align #(.XLEN(XLEN)) u_align (
        .raw_i        (mem_load_data),
        .off_i        (mem_addr_lo),
        .funct3_i     (mem_funct3),
        .data_o       (fmt_data),
        .misaligned_o (fmt_mis)
    );

    // Build the entry to store: loads take the formatted word, a misaligned
    // load never writes the register file
    always_comb begin
        in_entry.misaligned = mem_memtoreg & fmt_mis;
        in_entry.wdata      = mem_memtoreg ? fmt_data : mem_rd_data;
        in_entry.write_addr = mem_write_addr;
        in_entry.regwrite   = mem_regwrite & ~in_entry.misaligned;
    end

    assign mem_ready = (state_q != TWO);
    assign wb_valid  = (state_q != EMPTY);
    assign accept    = mem_valid & mem_ready;
    assign consume   = wb_valid & wb_ready;

    // Next-state and entry movement between the input, head and skid slots
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        h_d     = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        h_d = in_entry;
                    end else if (accept) begin
                        s_d     = in_entry;
                        state_d = TWO;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        h_d     = s_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and storage registers; reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            h_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
        end
    end

    assign wb_wdata      = h_q.wdata;
    assign wb_write_addr = h_q.write_addr;
    assign wb_regwrite   = wb_valid & h_q.regwrite;
    assign wb_misaligned = wb_valid & h_q.misaligned;

endmodule
